// File: rtl/hsid_pkg.sv
// ---------------------------------------------------------------------------
// hsid_pkg
// Shared types and constants for the hyperspectral pixel-distance blocks.
//   HSID_DATA_WIDTH   default band sample width (unsigned)
//   HSID_MAX_BANDS    default maximum bands per vector
//   sda_state_t       state encoding of hsid_sq_diff_acc
//   hsid_acc_width()  width of a sum of MAX_BANDS squared DATA_WIDTH-bit
//                     differences; sized so the sum can never wrap
// ---------------------------------------------------------------------------
package hsid_pkg;

    localparam int HSID_DATA_WIDTH = 16;
    localparam int HSID_MAX_BANDS  = 128;

    typedef enum logic [1:0] {
        SDA_IDLE  = 2'd0,
        SDA_READ  = 2'd1,
        SDA_DRAIN = 2'd2
    } sda_state_t;

    // One square needs 2*data_width bits; summing max_bands of them adds
    // log2(max_bands) bits of headroom.
    function automatic int hsid_acc_width(input int data_width, input int max_bands);
        return 2 * data_width + $clog2(max_bands);
    endfunction

endpackage

// File: rtl/hsid_sq_df.sv
// ---------------------------------------------------------------------------
// hsid_sq_df
// Two registered stages computing the square of an unsigned difference,
// with a valid bit carried alongside the data.
//   S1: |a-b|   (DATA_WIDTH bits, compare-then-subtract)
//   S2: |a-b|^2 (2*DATA_WIDTH bits)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush of both valid bits
//   in_valid     a/b carry a sample pair this cycle
//   a, b         unsigned samples
//   out_valid    sq carries a result this cycle
//   sq           registered square
//   active       any stage holds a valid sample
// ---------------------------------------------------------------------------
module hsid_sq_df
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH = HSID_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] sq,
    output logic                    active
);

    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_diff;
    logic [2*DATA_WIDTH-1:0] diff_wide;

    // Widen before multiplying so the product keeps all 2*DATA_WIDTH bits.
    assign diff_wide = {{DATA_WIDTH{1'b0}}, s1_diff};
    assign active    = s1_valid | out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            out_valid <= 1'b0;
            sq        <= '0;
        end else if (clear) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_diff <= (a >= b) ? (a - b) : (b - a);
            end
            if (s1_valid) begin
                sq <= diff_wide * diff_wide;
            end
        end
    end

endmodule

// File: rtl/hsid_sq_diff_acc.sv
// ---------------------------------------------------------------------------
// hsid_sq_diff_acc
// Pops a pixel FIFO and a reference FIFO in lockstep, squares the per-band
// difference and sums it over band_count bands; one distance per vector.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort, back to IDLE with nothing pending
//   start, band_count   begin a vector of band_count bands (IDLE only)
//   fifo_a_*            pixel FIFO data_out / empty / rd_en
//   fifo_b_*            reference FIFO data_out / empty / rd_en
//   busy                not in IDLE
//   acc_value           last final sum, held until next start or clear
//   acc_valid           one-cycle pulse when acc_value becomes final
// ---------------------------------------------------------------------------
module hsid_sq_diff_acc
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH = HSID_DATA_WIDTH,
    parameter int MAX_BANDS  = HSID_MAX_BANDS,
    parameter int BAND_WIDTH = $clog2(MAX_BANDS + 1),
    parameter int ACC_WIDTH  = hsid_acc_width(DATA_WIDTH, MAX_BANDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic [BAND_WIDTH-1:0] band_count,
    input  logic [DATA_WIDTH-1:0] fifo_a_data,
    input  logic                  fifo_a_empty,
    output logic                  fifo_a_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_b_data,
    input  logic                  fifo_b_empty,
    output logic                  fifo_b_rd_en,
    output logic                  busy,
    output logic [ACC_WIDTH-1:0]  acc_value,
    output logic                  acc_valid
);

    sda_state_t state, state_next;

    logic [BAND_WIDTH-1:0]   count_q;
    logic [BAND_WIDTH-1:0]   issued;
    logic [BAND_WIDTH-1:0]   issued_inc;
    logic                    read_ok;
    logic                    s0_valid;
    logic                    s2_valid;
    logic [2*DATA_WIDTH-1:0] s2_sq;
    logic                    pipe_active;
    logic                    pipe_idle;
    logic [ACC_WIDTH-1:0]    acc;

    // A read is issued only when both FIFOs have data, so the two enables
    // are one signal. clear suppresses it so an abort never pops a sample.
    assign read_ok      = (state == SDA_READ) && !clear && !fifo_a_empty &&
                          !fifo_b_empty && (issued < count_q);
    assign fifo_a_rd_en = read_ok;
    assign fifo_b_rd_en = read_ok;
    assign issued_inc   = issued + BAND_WIDTH'(1);
    assign pipe_idle    = !s0_valid && !pipe_active;
    assign busy         = (state != SDA_IDLE);

    // FIFO read latency is one cycle, so S0 is the FIFO output itself,
    // qualified by rd_en delayed one cycle.
    hsid_sq_df #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sq_df (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (s0_valid),
        .a         (fifo_a_data),
        .b         (fifo_b_data),
        .out_valid (s2_valid),
        .sq        (s2_sq),
        .active    (pipe_active)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SDA_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SDA_IDLE: begin
                if (start && (band_count != '0)) begin
                    state_next = SDA_READ;
                end
            end
            SDA_READ: begin
                if (read_ok && (issued_inc == count_q)) begin
                    state_next = SDA_DRAIN;
                end
            end
            SDA_DRAIN: begin
                if (pipe_idle) begin
                    state_next = SDA_IDLE;
                end
            end
            default: state_next = SDA_IDLE;
        endcase
        if (clear) begin
            state_next = SDA_IDLE;
        end
    end

    // Counters, accumulator and result. A zero-band vector finishes straight
    // from IDLE with an all-zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            issued    <= '0;
            s0_valid  <= 1'b0;
            acc       <= '0;
            acc_value <= '0;
            acc_valid <= 1'b0;
        end else if (clear) begin
            count_q   <= '0;
            issued    <= '0;
            s0_valid  <= 1'b0;
            acc       <= '0;
            acc_value <= '0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            s0_valid  <= read_ok;
            if ((state == SDA_IDLE) && start) begin
                count_q   <= band_count;
                issued    <= '0;
                acc       <= '0;
                acc_value <= '0;
                if (band_count == '0) begin
                    acc_valid <= 1'b1;
                end
            end
            if (read_ok) begin
                issued <= issued_inc;
            end
            if (s2_valid) begin
                acc <= acc + {{(ACC_WIDTH - 2*DATA_WIDTH){1'b0}}, s2_sq};
            end
            if ((state == SDA_DRAIN) && pipe_idle) begin
                acc_value <= acc;
                acc_valid <= 1'b1;
            end
        end
    end

endmodule
